// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a COM-loader port onto one synchronous single-port data memory.
// One transaction in flight at a time; on contention the port not granted last wins.
module mem_arbiter #(
  parameter int unsigned I = 32,
  parameter int unsigned N = 8,
  parameter int unsigned R = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [I-1:0]   cpu_addr,
  input  logic [R*N-1:0] cpu_wdata,
  output logic           cpu_gnt,
  output logic           cpu_rvalid,
  output logic [R*N-1:0] cpu_rdata,
  output logic           cpu_stall,
  input  logic           com_req,
  input  logic           com_we,
  input  logic [I-1:0]   com_addr,
  input  logic [R*N-1:0] com_wdata,
  output logic           com_gnt,
  output logic           com_rvalid,
  output logic [R*N-1:0] com_rdata,
  output logic [I-1:0]   mem_addr,
  output logic [R*N-1:0] mem_wdata,
  output logic           mem_we,
  output logic           mem_en,
  input  logic [R*N-1:0] mem_rdata,
  output logic [15:0]    conflict_cnt
);

  typedef enum logic [1:0] {IDLE, GNT, WAIT} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_COM = 1'b1} owner_t;

  state_t         state_q, state_d;
  owner_t         owner_q, owner_d;
  owner_t         last_owner_q, last_owner_d;
  owner_t         win;
  logic [I-1:0]   addr_q, addr_d;
  logic           we_q, we_d;
  logic [R*N-1:0] wdata_q, wdata_d;
  logic           cpu_gnt_q, cpu_gnt_d, com_gnt_q, com_gnt_d;
  logic           cpu_rvalid_q, cpu_rvalid_d, com_rvalid_q, com_rvalid_d;
  logic [R*N-1:0] cpu_rdata_q, cpu_rdata_d, com_rdata_q, com_rdata_d;
  logic           mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           contend;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cpu_gnt_d    = 1'b0;
    com_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    com_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    com_rdata_d  = com_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    cnt_d        = cnt_q;
    win          = OWN_CPU;
    contend      = 1'b0;

    case (state_q)
      IDLE: begin
        contend = cpu_req && com_req;
        if (cpu_req && com_req) begin
          win = (last_owner_q == OWN_COM) ? OWN_CPU : OWN_COM;
        end else if (com_req) begin
          win = OWN_COM;
        end
        if (cpu_req || com_req) begin
          owner_d      = win;
          last_owner_d = win;
          addr_d       = (win == OWN_CPU) ? cpu_addr  : com_addr;
          we_d         = (win == OWN_CPU) ? cpu_we    : com_we;
          wdata_d      = (win == OWN_CPU) ? cpu_wdata : com_wdata;
          cpu_gnt_d    = (win == OWN_CPU);
          com_gnt_d    = (win == OWN_COM);
          mem_en_d     = 1'b1;
          mem_we_d     = (win == OWN_CPU) ? cpu_we : com_we;
          state_d      = GNT;
        end
      end
      GNT: begin
        contend = (owner_q == OWN_CPU) ? com_req : cpu_req;
        state_d = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        contend = (owner_q == OWN_CPU) ? com_req : cpu_req;
        // Read data is valid during WAIT; capture it on the edge leaving WAIT
        if (owner_q == OWN_CPU) begin
          cpu_rdata_d  = mem_rdata;
          cpu_rvalid_d = 1'b1;
        end else begin
          com_rdata_d  = mem_rdata;
          com_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (contend && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_COM;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cpu_gnt_q    <= 1'b0;
      com_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      com_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      com_rdata_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      com_gnt_q    <= com_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      com_rvalid_q <= com_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      com_rdata_q  <= com_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    cpu_gnt      = cpu_gnt_q;
    com_gnt      = com_gnt_q;
    cpu_rvalid   = cpu_rvalid_q;
    com_rvalid   = com_rvalid_q;
    cpu_rdata    = cpu_rdata_q;
    com_rdata    = com_rdata_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    mem_en       = mem_en_q;
    mem_we       = mem_we_q;
    conflict_cnt = cnt_q;
    // Stall releases only in the write-grant or read-return cycle; held low in reset
    cpu_stall    = reset && cpu_req && !(cpu_gnt_q && mem_we_q) && !cpu_rvalid_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected strobes,
// a negedge monitor pops and compares whenever a gnt or rvalid appears.
module tb_mem_arbiter;

  localparam int K_CPU_GNT = 0;
  localparam int K_COM_GNT = 1;
  localparam int K_CPU_RV  = 2;
  localparam int K_COM_RV  = 3;

  logic        clk, reset;
  logic        cpu_req, cpu_we, com_req, com_we;
  logic [31:0] cpu_addr, com_addr, mem_addr;
  logic [47:0] cpu_wdata, com_wdata, cpu_rdata, com_rdata, mem_wdata, mem_rdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, com_gnt, com_rvalid, mem_we, mem_en;
  logic [15:0] conflict_cnt;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [47:0] data;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_e;
  int          mon_n, mon_kind;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          t, r;
  bit          mon_en;
  logic [47:0] mem [0:255];

  localparam logic [47:0] D_WR = 48'h06_05_04_03_02_01;
  localparam logic [47:0] D_AA = 48'hAA_AA_AA_AA_AA_AA;
  localparam logic [47:0] D_30 = 48'h66_55_44_33_22_11;
  localparam logic [47:0] D_40 = 48'h0F_0E_0D_0C_0B_0A;

  mem_arbiter #(.I(32), .N(8), .R(6)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .com_req(com_req), .com_we(com_we), .com_addr(com_addr), .com_wdata(com_wdata),
    .com_gnt(com_gnt), .com_rvalid(com_rvalid), .com_rdata(com_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_en(mem_en),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory model: read data appears the cycle after the enable
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(input int kind, input int c, input logic [31:0] a,
                               input logic we, input logic [47:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.we = we; e.data = d;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_n = int'(cpu_gnt) + int'(com_gnt) + int'(cpu_rvalid) + int'(com_rvalid);
      if (mon_n != 0) begin
        chk("one_strobe", mon_n, 1);
        mon_kind = cpu_gnt ? K_CPU_GNT : com_gnt ? K_COM_GNT : cpu_rvalid ? K_CPU_RV : K_COM_RV;
        if (sb.size() == 0) begin
          chk("unexpected_strobe", mon_kind, 255);
        end else begin
          mon_e = sb.pop_front();
          chk("strobe_kind", mon_kind, mon_e.kind);
          chk("strobe_cycle", cyc, mon_e.cyc);
          if (mon_kind < 2) begin
            chk("gnt_mem_en", mem_en, 1);
            chk("gnt_mem_we", mem_we, mon_e.we);
            chk("gnt_mem_addr", mem_addr, mon_e.addr);
            if (mon_e.we) chk("gnt_mem_wdata", mem_wdata, mon_e.data);
          end else begin
            chk("rdata", (mon_kind == K_CPU_RV) ? cpu_rdata : com_rdata, mon_e.data);
          end
        end
      end
    end
  end

  // Single uncontended COM read; req dropped in the grant cycle
  task automatic com_read(input logic [31:0] a, input logic [47:0] exp);
    t = cyc;
    com_req = 1'b1; com_we = 1'b0; com_addr = a;
    push(K_COM_GNT, t + 1, a, 1'b0, '0);
    push(K_COM_RV, t + 3, '0, 1'b0, exp);
    tick();
    com_req = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = D_AA;
    mem[8'h30] = D_30;
    mem[8'h40] = D_40;
    mem_rdata = '0;
    mon_en = 1'b1;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    com_req = 1'b0; com_we = 1'b0; com_addr = '0; com_wdata = '0;
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_gnts", {cpu_gnt, com_gnt, cpu_rvalid, com_rvalid}, 0);
    chk("rst_mem_ctl", {mem_en, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {cpu_rdata, com_rdata}, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    reset = 1'b1;
    tick();

    // CPU write, COM idle
    t = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = D_WR;
    push(K_CPU_GNT, t + 1, 32'h10, 1'b1, D_WR);
    #1 chk("stall_req_idle", cpu_stall, 1);
    tick();
    chk("stall_wr_gnt", cpu_stall, 0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    chk("idle_mem_en_we", {mem_en, mem_we}, 0);
    chk("idle_mem_addr_hold", mem_addr, 32'h10);

    // COM reads: preset pattern, then the lanes the CPU just wrote
    com_read(32'h20, D_AA);
    tick();
    chk("com_rdata_hold", com_rdata, D_AA);
    com_read(32'h10, D_WR);

    // CPU request arrives while COM owns the grant
    t = cyc;
    com_req = 1'b1; com_we = 1'b0; com_addr = 32'h30;
    push(K_COM_GNT, t + 1, 32'h30, 1'b0, '0);
    push(K_COM_RV,  t + 3, '0, 1'b0, D_30);
    push(K_CPU_GNT, t + 4, 32'h40, 1'b0, '0);
    push(K_CPU_RV,  t + 6, '0, 1'b0, D_40);
    tick();
    com_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    #1 chk("stall_com_gnt", cpu_stall, 1);
    chk("addr_com_gnt", mem_addr, 32'h30);
    tick();
    chk("stall_com_wait", cpu_stall, 1);
    chk("addr_com_wait", mem_addr, 32'h30);
    tick();
    chk("stall_com_rv", cpu_stall, 1);
    chk("addr_com_rv", mem_addr, 32'h30);
    tick();
    chk("stall_cpu_gnt_rd", cpu_stall, 1);
    chk("cnt_after_overlap", conflict_cnt, 2);
    tick();
    chk("stall_cpu_wait", cpu_stall, 1);
    tick();
    chk("stall_cpu_rv", cpu_stall, 0);
    cpu_req = 1'b0;
    tick();
    chk("cnt_hold", conflict_cnt, 2);

    // Reset during a CPU read's WAIT aborts it; held request is re-granted afterwards
    t = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    push(K_CPU_GNT, t + 1, 32'h20, 1'b0, '0);
    tick(); tick();
    reset = 1'b0;
    #1 chk("abort_strobes", {cpu_gnt, com_gnt, cpu_rvalid, com_rvalid}, 0);
    chk("abort_mem", {mem_en, mem_we, mem_addr}, 0);
    chk("abort_rdata", cpu_rdata, 0);
    chk("abort_cnt", conflict_cnt, 0);
    chk("abort_stall", cpu_stall, 0);
    tick(); tick();
    reset = 1'b1;
    r = cyc;
    push(K_CPU_GNT, r + 1, 32'h20, 1'b0, '0);
    push(K_CPU_RV,  r + 3, '0, 1'b0, D_AA);
    tick();
    cpu_req = 1'b0;
    tick(); tick(); tick();

    // Both reads held from reset: CPU, COM, CPU at 3-cycle spacing
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30;
    com_req = 1'b1; com_we = 1'b0; com_addr = 32'h40;
    tick();
    reset = 1'b1;
    r = cyc;
    push(K_CPU_GNT, r + 1, 32'h30, 1'b0, '0);
    push(K_CPU_RV,  r + 3, '0, 1'b0, D_30);
    push(K_COM_GNT, r + 4, 32'h40, 1'b0, '0);
    push(K_COM_RV,  r + 6, '0, 1'b0, D_40);
    push(K_CPU_GNT, r + 7, 32'h30, 1'b0, '0);
    push(K_CPU_RV,  r + 9, '0, 1'b0, D_30);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 3) chk("contend_cnt3", conflict_cnt, 3);
      if (k == 6) chk("contend_cnt6", conflict_cnt, 6);
      if (k == 7) begin
        chk("contend_cnt7", conflict_cnt, 7);
        cpu_req = 1'b0; com_req = 1'b0;
      end
      if (k == 9) chk("contend_cnt_stop", conflict_cnt, 7);
    end
    tick();

    // Continuous contention drives the counter into saturation
    mon_en = 1'b0;
    reset = 1'b0;
    cpu_req = 1'b1; com_req = 1'b1;
    tick();
    reset = 1'b1;
    repeat (65534) tick();
    chk("sat_fffe", conflict_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", conflict_cnt, 16'hFFFF);
    repeat (10) tick();
    chk("sat_stays", conflict_cnt, 16'hFFFF);
    cpu_req = 1'b0; com_req = 1'b0;
    tick(); tick(); tick(); tick();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
